// File: rtl/serial_mod_pkg.sv
// Shared types and helpers for the serial MSB-first divisibility checker.
// The mod step is a constant-divisor restoring subtract chain, not a divider.
package serial_mod_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } lane_state_t;

    function automatic int unsigned rem_w(input int unsigned divisor);
        return (divisor <= 2) ? 1 : $clog2(divisor);
    endfunction

    // Input range is below divisor * 2^sym_w, so subtracting divisor << k for
    // k = sym_w-1 .. 0 leaves the value below divisor after the last stage.
    function automatic int unsigned mod_step(input int unsigned divisor,
                                             input int unsigned sym_w,
                                             input int unsigned rem,
                                             input int unsigned digit);
        int unsigned v;
        v = (rem << sym_w) + digit;
        for (int unsigned i = sym_w; i > 0; i--) begin
            if (v >= (divisor << (i - 1)))
                v = v - (divisor << (i - 1));
        end
        return v;
    endfunction

endpackage

// File: rtl/serial_mod_lane.sv
// One channel: running remainder, lane state and saturating digit counter.
module serial_mod_lane
    import serial_mod_pkg::*;
#(
    parameter  int unsigned DIVISOR = 5,
    parameter  int unsigned SYM_W   = 1,
    parameter  int unsigned CNT_W   = 8,
    localparam int unsigned REM_W   = rem_w(DIVISOR)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [SYM_W-1:0] din,
    output logic             dout,
    output logic [REM_W-1:0] rem_out,
    output logic             active,
    output logic [CNT_W-1:0] dig_cnt
);

    lane_state_t      state_q, state_n;
    logic [REM_W-1:0] rem_q, rem_n, base;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             dout_q;
    logic             restart;

    always_comb begin
        state_n = state_q;
        rem_n   = rem_q;
        cnt_n   = cnt_q;
        restart = 1'b0;
        base    = '0;
        if (in_valid) begin
            restart = (state_q == IDLE) || in_sof;
            base    = restart ? '0 : rem_q;
            rem_n   = REM_W'(mod_step(DIVISOR, SYM_W, 32'(base), 32'(din)));
            cnt_n   = restart ? CNT_W'(1) : ((&cnt_q) ? cnt_q : cnt_q + 1'b1);
            state_n = RUN;
        end
    end

    // dout is decoded from next-state values so it lines up with rem_out.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            rem_q   <= '0;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            rem_q   <= rem_n;
            cnt_q   <= cnt_n;
            dout_q  <= (state_n == RUN) && (rem_n == '0);
        end
    end

    assign dout    = dout_q;
    assign rem_out = rem_q;
    assign active  = (state_q == RUN);
    assign dig_cnt = cnt_q;

endmodule

// File: rtl/serial_mod_checker.sv
// Multi-channel divisibility checker for serial MSB-first numbers.
// Only slices the packed buses and instantiates one lane per channel.
module serial_mod_checker
    import serial_mod_pkg::*;
#(
    parameter  int unsigned DIVISOR = 5,
    parameter  int unsigned NUM_CH  = 4,
    parameter  int unsigned SYM_W   = 1,
    parameter  int unsigned CNT_W   = 8,
    localparam int unsigned REM_W   = rem_w(DIVISOR)
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH-1:0]       in_sof,
    input  logic [NUM_CH*SYM_W-1:0] din,
    output logic [NUM_CH-1:0]       dout,
    output logic [NUM_CH*REM_W-1:0] rem_out,
    output logic [NUM_CH-1:0]       active,
    output logic [NUM_CH*CNT_W-1:0] dig_cnt
);

    if (DIVISOR < 2) begin : g_bad_divisor
        $error("serial_mod_checker: DIVISOR must be >= 2");
    end
    if (NUM_CH < 1 || SYM_W < 1 || CNT_W < 1) begin : g_bad_width
        $error("serial_mod_checker: NUM_CH, SYM_W and CNT_W must be >= 1");
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        serial_mod_lane #(
            .DIVISOR (DIVISOR),
            .SYM_W   (SYM_W),
            .CNT_W   (CNT_W)
        ) u_lane (
            .clk      (clk),
            .resetn   (resetn),
            .in_valid (in_valid[c]),
            .in_sof   (in_sof[c]),
            .din      (din[c*SYM_W +: SYM_W]),
            .dout     (dout[c]),
            .rem_out  (rem_out[c*REM_W +: REM_W]),
            .active   (active[c]),
            .dig_cnt  (dig_cnt[c*CNT_W +: CNT_W])
        );
    end

endmodule
